// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: defaults, opcode and FSM encoding.
package fetch_pkg;

    localparam int          XLEN_DEF     = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [6:0]  OPCODE_JAL   = 7'b1101111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } fetch_state_t;

    // J-type immediate, bit 0 implied zero; callers sign-extend to their PC width.
    function automatic logic signed [20:0] jal_imm(input logic [31:0] inst);
        return {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Power-of-two synchronous FIFO with a combinational head and a clear that beats push/pop.
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     clear,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    always_ff @(posedge clk_in) begin
        if (rst_in || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; the occupancy count decides what is meaningful.
    always_ff @(posedge clk_in) begin
        if (push && !clear) mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

    a_no_overflow: assert property (@(posedge clk_in) disable iff (rst_in || clear)
        !(push && !pop && (count == (AW+1)'(DEPTH))));
    a_no_underflow: assert property (@(posedge clk_in) disable iff (rst_in || clear)
        !(pop && (count == '0)));

endmodule

// File: rtl/inst_fetch_queue.sv
// Fetch stage: one outstanding cache request, JAL predecode redirect, flush with stale-response drop.
module inst_fetch_queue
    import fetch_pkg::*;
#(
    parameter int              DEPTH         = 4,
    parameter int              XLEN          = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_PC      = XLEN'(RESET_PC_DEF),
    parameter int              PREDECODE_JAL = 1
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    output logic                     mem_req_valid,
    output logic [XLEN-1:0]          mem_req_addr,
    input  logic                     mem_req_ready,
    input  logic                     mem_resp_valid,
    input  logic [31:0]              mem_resp_inst,
    output logic                     dec_valid,
    output logic [31:0]              dec_inst,
    output logic [XLEN-1:0]          dec_pc,
    input  logic                     dec_ready,
    input  logic                     RoB_clear,
    input  logic [XLEN-1:0]          RoB_clear_pc_value,
    output logic [$clog2(DEPTH):0]   queue_count
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = 32 + XLEN;

    fetch_state_t    state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] req_pc;
    logic [XLEN-1:0] pc_step;
    logic [XLEN-1:0] next_pc;
    logic            is_jal;
    logic            handshake;
    logic            push;
    logic            pop;
    logic            clear;
    logic [EW-1:0]   head;
    logic [CW-1:0]   count;

    // A request is only offered while a queue slot is guaranteed for its response.
    assign mem_req_valid = !rst_in && (state == ST_IDLE) && (count < CW'(DEPTH));
    assign mem_req_addr  = pc;
    assign handshake     = rdy_in && mem_req_valid && mem_req_ready;

    assign is_jal  = (PREDECODE_JAL != 0) && (mem_resp_inst[6:0] == OPCODE_JAL);
    assign pc_step = is_jal ? XLEN'(jal_imm(mem_resp_inst)) : XLEN'(4);
    assign next_pc = req_pc + pc_step;

    assign push  = rdy_in && !RoB_clear && (state == ST_WAIT) && mem_resp_valid;
    assign pop   = rdy_in && dec_valid && dec_ready;
    assign clear = rdy_in && RoB_clear;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= ST_IDLE;
            pc    <= RESET_PC;
        end else if (rdy_in) begin
            if (RoB_clear) begin
                pc <= RoB_clear_pc_value;
                // Any request already accepted belongs to the old stream and must be swallowed.
                case (state)
                    ST_IDLE:          state <= handshake ? ST_DROP : ST_IDLE;
                    ST_WAIT, ST_DROP: state <= mem_resp_valid ? ST_IDLE : ST_DROP;
                    default:          state <= ST_IDLE;
                endcase
            end else begin
                case (state)
                    ST_IDLE: if (handshake) state <= ST_WAIT;
                    ST_WAIT: if (mem_resp_valid) begin
                        pc    <= next_pc;
                        state <= ST_IDLE;
                    end
                    ST_DROP: if (mem_resp_valid) state <= ST_IDLE;
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (handshake && !RoB_clear) req_pc <= pc;
    end

    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .clear     (clear),
        .push      (push),
        .push_data ({mem_resp_inst, req_pc}),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

    // Head fields are masked while empty so the unreset storage never reaches the decoder.
    assign dec_valid   = (count != '0);
    assign dec_inst    = dec_valid ? head[EW-1:XLEN] : '0;
    assign dec_pc      = dec_valid ? head[XLEN-1:0] : '0;
    assign queue_count = count;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Randomized and directed bench for inst_fetch_queue against a queue-based fetch model.
module tb_inst_fetch_queue;

    localparam int DEPTH = 4;
    localparam int XLEN  = 32;

    logic clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    logic            rst_in, rdy_in, mem_req_ready, mem_resp_valid, dec_ready, RoB_clear;
    logic [31:0]     mem_resp_inst;
    logic [XLEN-1:0] RoB_clear_pc_value;

    logic            mem_req_valid, dec_valid, mem_req_valid_b, dec_valid_b;
    logic [XLEN-1:0] mem_req_addr, dec_pc, mem_req_addr_b, dec_pc_b;
    logic [31:0]     dec_inst, dec_inst_b;
    logic [2:0]      queue_count, queue_count_b;

    int checks = 0;
    int errors = 0;

    inst_fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .PREDECODE_JAL(1)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
        .mem_resp_valid(mem_resp_valid), .mem_resp_inst(mem_resp_inst),
        .dec_valid(dec_valid), .dec_inst(dec_inst), .dec_pc(dec_pc), .dec_ready(dec_ready),
        .RoB_clear(RoB_clear), .RoB_clear_pc_value(RoB_clear_pc_value), .queue_count(queue_count)
    );

    inst_fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .PREDECODE_JAL(0)) dut_nopd (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .mem_req_valid(mem_req_valid_b), .mem_req_addr(mem_req_addr_b), .mem_req_ready(mem_req_ready),
        .mem_resp_valid(mem_resp_valid), .mem_resp_inst(mem_resp_inst),
        .dec_valid(dec_valid_b), .dec_inst(dec_inst_b), .dec_pc(dec_pc_b), .dec_ready(dec_ready),
        .RoB_clear(RoB_clear), .RoB_clear_pc_value(RoB_clear_pc_value), .queue_count(queue_count_b)
    );

    // Reference model: instruction queue, fetch PC, and whether a request is in flight / stale.
    logic [63:0]     m_q[$];
    logic [XLEN-1:0] m_pc, m_rpc, m_pc1, m_rpc1;
    bit              m_busy, m_stale;

    function automatic logic [31:0] inst_for(input logic [31:0] pc);
        return {pc[24:0], 7'h13};
    endfunction

    function automatic logic [31:0] next_pc(input logic [31:0] rp, input logic [31:0] inst, input bit pd);
        logic [20:0] imm;
        imm = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
        if (pd && inst[6:0] == 7'h6F) return rp + {{11{imm[20]}}, imm};
        return rp + 32'd4;
    endfunction

    function automatic bit exp_req_valid();
        return !rst_in && !m_busy && (m_q.size() < DEPTH);
    endfunction

    function automatic logic [31:0] exp_inst();
        return (m_q.size() != 0) ? m_q[0][63:32] : 32'h0;
    endfunction

    function automatic logic [31:0] exp_pc();
        return (m_q.size() != 0) ? m_q[0][31:0] : 32'h0;
    endfunction

    task automatic model_update();
        bit hs, rsp, pp;
        if (rst_in) begin
            m_q.delete();
            m_pc = '0; m_pc1 = '0; m_busy = 0; m_stale = 0;
        end else if (rdy_in) begin
            hs  = exp_req_valid() && mem_req_ready;
            rsp = m_busy && mem_resp_valid;
            pp  = (m_q.size() != 0) && dec_ready;
            if (RoB_clear) begin
                m_q.delete();
                m_pc = RoB_clear_pc_value; m_pc1 = RoB_clear_pc_value;
                if (hs) begin m_busy = 1; m_stale = 1; end
                else if (rsp) m_busy = 0;
                else if (m_busy) m_stale = 1;
            end else begin
                if (pp) void'(m_q.pop_front());
                if (rsp) begin
                    if (!m_stale) begin
                        m_q.push_back({mem_resp_inst, m_rpc});
                        m_pc  = next_pc(m_rpc, mem_resp_inst, 1);
                        m_pc1 = next_pc(m_rpc1, mem_resp_inst, 0);
                    end
                    m_busy = 0;
                end
                if (hs) begin m_busy = 1; m_stale = 0; m_rpc = m_pc; m_rpc1 = m_pc1; end
            end
        end
    endtask

    task automatic tick();
        model_update();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        rst_in = 1; rdy_in = 1; RoB_clear = 0; mem_req_ready = 0; mem_resp_valid = 0;
        dec_ready = 0; mem_resp_inst = '0; RoB_clear_pc_value = '0;
        tick();
        rst_in = 0;
    endtask

    task automatic test_reset();
        do_reset();
        rst_in = 1;
        tick();
        checks += 6;
        if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid got %0b want 0", mem_req_valid); end
        if (mem_req_addr !== 32'h0) begin errors++; $display("FAIL reset_req_addr got %h want 0", mem_req_addr); end
        if (dec_valid !== 1'b0) begin errors++; $display("FAIL reset_dec_valid got %0b want 0", dec_valid); end
        if (dec_inst !== 32'h0) begin errors++; $display("FAIL reset_dec_inst got %h want 0", dec_inst); end
        if (dec_pc !== 32'h0) begin errors++; $display("FAIL reset_dec_pc got %h want 0", dec_pc); end
        if (queue_count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", queue_count); end
        rst_in = 0;
        #1;
        checks++;
        if (mem_req_valid !== 1'b1) begin errors++; $display("FAIL post_reset_req_valid got %0b want 1", mem_req_valid); end
    endtask

    task automatic test_stream();
        logic [31:0] req_a[$], dq_pc[$], dq_inst[$];
        do_reset();
        dec_ready = 1;
        for (int c = 0; c < 12; c++) begin
            mem_req_ready = 1; mem_resp_valid = m_busy; mem_resp_inst = inst_for(m_rpc);
            #1;
            if (mem_req_valid) req_a.push_back(mem_req_addr);
            if (dec_valid) begin dq_pc.push_back(dec_pc); dq_inst.push_back(dec_inst); end
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (req_a.size() <= i || req_a[i] !== 32'(4 * i)) begin
                errors++; $display("FAIL stream_req_addr[%0d] got %h want %h", i, (req_a.size() > i) ? req_a[i] : 32'hx, 32'(4 * i));
            end
        end
        for (int i = 0; i < 3; i++) begin
            checks += 2;
            if (dq_pc.size() <= i || dq_pc[i] !== 32'(4 * i)) begin
                errors++; $display("FAIL stream_dec_pc[%0d] got %h want %h", i, (dq_pc.size() > i) ? dq_pc[i] : 32'hx, 32'(4 * i));
            end
            if (dq_inst.size() <= i || dq_inst[i] !== inst_for(32'(4 * i))) begin
                errors++; $display("FAIL stream_dec_inst[%0d] got %h want %h", i, (dq_inst.size() > i) ? dq_inst[i] : 32'hx, inst_for(32'(4 * i)));
            end
        end
    endtask

    task automatic test_full();
        do_reset();
        dec_ready = 0;
        for (int c = 0; c < 14; c++) begin
            mem_req_ready = 1; mem_resp_valid = m_busy; mem_resp_inst = inst_for(m_rpc);
            tick();
        end
        mem_resp_valid = 0;
        checks += 3;
        if (queue_count !== 3'd4) begin errors++; $display("FAIL full_count got %0d want 4", queue_count); end
        if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL full_req_valid got %0b want 0", mem_req_valid); end
        if (dec_pc !== 32'h0) begin errors++; $display("FAIL full_head_pc got %h want 0", dec_pc); end
        dec_ready = 1;
        tick();
        dec_ready = 0;
        checks += 3;
        if (queue_count !== 3'd3) begin errors++; $display("FAIL full_pop_count got %0d want 3", queue_count); end
        if (mem_req_valid !== 1'b1) begin errors++; $display("FAIL full_pop_req_valid got %0b want 1", mem_req_valid); end
        if (mem_req_addr !== 32'd16) begin errors++; $display("FAIL full_pop_req_addr got %h want 10", mem_req_addr); end
    endtask

    task automatic test_jal();
        logic [31:0] ra[$], rb[$];
        do_reset();
        dec_ready = 1;
        for (int c = 0; c < 10; c++) begin
            mem_req_ready = 1; mem_resp_valid = m_busy;
            mem_resp_inst = (m_rpc == 32'd8) ? 32'h0100006F : inst_for(m_rpc);
            #1;
            if (mem_req_valid) ra.push_back(mem_req_addr);
            if (mem_req_valid_b) rb.push_back(mem_req_addr_b);
            tick();
        end
        checks += 2;
        if (ra.size() < 4 || ra[3] !== 32'd24) begin
            errors++; $display("FAIL jal_predecode_addr got %h want 18", (ra.size() > 3) ? ra[3] : 32'hx);
        end
        if (rb.size() < 4 || rb[3] !== 32'd12) begin
            errors++; $display("FAIL jal_nopredecode_addr got %h want c", (rb.size() > 3) ? rb[3] : 32'hx);
        end
    endtask

    task automatic test_flush_wait();
        do_reset();
        mem_req_ready = 1;
        tick();
        mem_req_ready = 0; RoB_clear = 1; RoB_clear_pc_value = 32'h200;
        tick();
        RoB_clear = 0;
        checks++;
        if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL flush_drop_req_valid got %0b want 0", mem_req_valid); end
        tick();
        mem_resp_valid = 1; mem_resp_inst = inst_for(32'h0);
        tick();
        mem_resp_valid = 0;
        checks += 4;
        if (mem_req_valid !== 1'b1) begin errors++; $display("FAIL flush_refetch_valid got %0b want 1", mem_req_valid); end
        if (mem_req_addr !== 32'h200) begin errors++; $display("FAIL flush_refetch_addr got %h want 200", mem_req_addr); end
        if (queue_count !== 3'd0) begin errors++; $display("FAIL flush_stale_count got %0d want 0", queue_count); end
        if (dec_valid !== 1'b0) begin errors++; $display("FAIL flush_dec_valid got %0b want 0", dec_valid); end
    endtask

    task automatic serve_first_pc(input logic [31:0] want, input string name);
        logic [31:0] first;
        bit seen;
        seen = 0; first = '0; dec_ready = 1;
        for (int c = 0; c < 6; c++) begin
            mem_req_ready = 1; mem_resp_valid = m_busy; mem_resp_inst = inst_for(m_rpc);
            #1;
            if (dec_valid && !seen) begin first = dec_pc; seen = 1; end
            tick();
        end
        mem_req_ready = 0; mem_resp_valid = 0; dec_ready = 0;
        checks++;
        if (!seen || first !== want) begin errors++; $display("FAIL %s got %h want %h", name, first, want); end
    endtask

    task automatic test_flush_same();
        do_reset();
        mem_req_ready = 1;
        tick();
        mem_req_ready = 0; mem_resp_valid = 1; mem_resp_inst = inst_for(32'h0);
        RoB_clear = 1; RoB_clear_pc_value = 32'h340;
        tick();
        RoB_clear = 0; mem_resp_valid = 0;
        checks += 3;
        if (queue_count !== 3'd0) begin errors++; $display("FAIL flush_resp_count got %0d want 0", queue_count); end
        if (mem_req_valid !== 1'b1) begin errors++; $display("FAIL flush_resp_req_valid got %0b want 1", mem_req_valid); end
        if (mem_req_addr !== 32'h340) begin errors++; $display("FAIL flush_resp_addr got %h want 340", mem_req_addr); end
        serve_first_pc(32'h340, "flush_resp_first_dec_pc");

        do_reset();
        mem_req_ready = 1; RoB_clear = 1; RoB_clear_pc_value = 32'h480;
        tick();
        RoB_clear = 0; mem_req_ready = 0;
        checks++;
        if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL flush_hs_drop_valid got %0b want 0", mem_req_valid); end
        mem_resp_valid = 1; mem_resp_inst = inst_for(32'h0);
        tick();
        mem_resp_valid = 0;
        checks += 2;
        if (queue_count !== 3'd0) begin errors++; $display("FAIL flush_hs_count got %0d want 0", queue_count); end
        if (mem_req_addr !== 32'h480) begin errors++; $display("FAIL flush_hs_addr got %h want 480", mem_req_addr); end
        serve_first_pc(32'h480, "flush_hs_first_dec_pc");
    endtask

    task automatic test_freeze();
        do_reset();
        RoB_clear = 1; RoB_clear_pc_value = 32'hFFFF_FFF8;
        tick();
        RoB_clear = 0; mem_req_ready = 1;
        tick();
        mem_req_ready = 0; mem_resp_valid = 1; mem_resp_inst = inst_for(32'hFFFF_FFF8);
        tick();
        mem_resp_valid = 0; mem_req_ready = 1;
        tick();
        mem_req_ready = 0;
        rdy_in = 0; mem_resp_valid = 1; mem_resp_inst = inst_for(32'hFFFF_FFFC); dec_ready = 1;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks += 3;
            if (queue_count !== 3'd1) begin errors++; $display("FAIL freeze_count[%0d] got %0d want 1", c, queue_count); end
            if (dec_pc !== 32'hFFFF_FFF8) begin errors++; $display("FAIL freeze_dec_pc[%0d] got %h want fffffff8", c, dec_pc); end
            if (mem_req_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL freeze_addr[%0d] got %h want fffffffc", c, mem_req_addr); end
        end
        rdy_in = 1;
        tick();
        mem_resp_valid = 0; dec_ready = 0;
        checks += 4;
        if (queue_count !== 3'd1) begin errors++; $display("FAIL resume_count got %0d want 1", queue_count); end
        if (dec_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL resume_dec_pc got %h want fffffffc", dec_pc); end
        if (mem_req_addr !== 32'h0) begin errors++; $display("FAIL wrap_addr got %h want 0", mem_req_addr); end
        if (mem_req_valid !== 1'b1) begin errors++; $display("FAIL wrap_req_valid got %0b want 1", mem_req_valid); end
    endtask

    task automatic test_random();
        logic [31:0] r;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            r = $urandom;
            rst_in         = ($urandom_range(199) == 0);
            rdy_in         = ($urandom_range(99) < 85);
            mem_req_ready  = ($urandom_range(99) < 70);
            mem_resp_valid = ($urandom_range(99) < 50);
            dec_ready      = ($urandom_range(99) < 60);
            RoB_clear      = ($urandom_range(99) < 4);
            RoB_clear_pc_value = $urandom & 32'hFFFF_FFFC;
            mem_resp_inst  = ($urandom_range(3) == 0) ? {r[31:7], 7'h6F} : {r[31:7], 7'h13};
            #1;
            checks += 8;
            if (mem_req_valid !== exp_req_valid()) begin errors++; $display("FAIL rnd_req_valid c%0d got %0b want %0b", c, mem_req_valid, exp_req_valid()); end
            if (mem_req_addr !== m_pc) begin errors++; $display("FAIL rnd_req_addr c%0d got %h want %h", c, mem_req_addr, m_pc); end
            if (dec_valid !== (m_q.size() != 0)) begin errors++; $display("FAIL rnd_dec_valid c%0d got %0b want %0b", c, dec_valid, m_q.size() != 0); end
            if (dec_inst !== exp_inst()) begin errors++; $display("FAIL rnd_dec_inst c%0d got %h want %h", c, dec_inst, exp_inst()); end
            if (dec_pc !== exp_pc()) begin errors++; $display("FAIL rnd_dec_pc c%0d got %h want %h", c, dec_pc, exp_pc()); end
            if (queue_count !== 3'(m_q.size())) begin errors++; $display("FAIL rnd_count c%0d got %0d want %0d", c, queue_count, m_q.size()); end
            if (mem_req_addr_b !== m_pc1) begin errors++; $display("FAIL rnd_nopd_addr c%0d got %h want %h", c, mem_req_addr_b, m_pc1); end
            if (queue_count_b !== 3'(m_q.size())) begin errors++; $display("FAIL rnd_nopd_count c%0d got %0d want %0d", c, queue_count_b, m_q.size()); end
            tick();
        end
        rst_in = 0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_full();
        test_jal();
        test_flush_wait();
        test_flush_same();
        test_freeze();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
